cola_solicitudes: RTL and testbench

Request-memory stage directly upstream of the elevator floor FSM. It latches the encoded button presses (codes 1–10) into a pending set and clears a floor's requests once the doors open there. Each cycle it applies a direction-preserving (SCAN) policy and presents the next instruction code on memoria, which the FSM samples at its 10 s decision instant.

---
 rtl/cola_solicitudes_pkg.sv | 51 +++++
 rtl/cola_solicitudes_if.sv | 30 +++
 rtl/cola_solicitudes_selector_scan.sv | 83 ++++++++
 rtl/cola_solicitudes.sv | 77 +++++++
 tb/tb_cola_solicitudes.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cola_solicitudes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cola_solicitudes_pkg
// Description : Shared constants, direction type and code/floor helpers for
//               the elevator request queue.
// Revision    : 1.0 - initial release
// ============================================================================
package cola_solicitudes_pkg;

  localparam int NUM_CODIGOS  = 10;
  localparam int ANCHO_CODIGO = 4;

  typedef enum logic [1:0] {
    DIR_IDLE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } dir_t;

  localparam logic [ANCHO_CODIGO-1:0] COD_NINGUNO = 4'd0;
  localparam logic [ANCHO_CODIGO-1:0] COD_MAX     = 4'd10;

  // Bit i-1 holds code i; cabin code of floor f sits at bit f.
  localparam logic [NUM_CODIGOS-1:0] MASCARA_PISO0 = 10'h011;
  localparam logic [NUM_CODIGOS-1:0] MASCARA_PISO1 = 10'h062;
  localparam logic [NUM_CODIGOS-1:0] MASCARA_PISO2 = 10'h184;
  localparam logic [NUM_CODIGOS-1:0] MASCARA_PISO3 = 10'h208;

  function automatic logic [1:0] codigo_a_piso(input logic [ANCHO_CODIGO-1:0] codigo);
    logic [1:0] piso;
    case (codigo)
      4'd2, 4'd6, 4'd7: piso = 2'd1;
      4'd3, 4'd8, 4'd9: piso = 2'd2;
      4'd4, 4'd10:      piso = 2'd3;
      default:          piso = 2'd0;
    endcase
    return piso;
  endfunction

  function automatic logic [NUM_CODIGOS-1:0] mascara_piso(input logic [1:0] piso);
    logic [NUM_CODIGOS-1:0] mascara;
    case (piso)
      2'd0:    mascara = MASCARA_PISO0;
      2'd1:    mascara = MASCARA_PISO1;
      2'd2:    mascara = MASCARA_PISO2;
      default: mascara = MASCARA_PISO3;
    endcase
    return mascara;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cola_solicitudes_if.sv
`default_nettype none
// ============================================================================
// Module      : cola_solicitudes_if
// Description : Bus between the floor FSM (master) and the request queue
//               (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface cola_solicitudes_if;

  logic                                           LE;
  logic                                           puertas;
  logic [1:0]                                     accion;
  logic [1:0]                                     piso;
  logic [cola_solicitudes_pkg::ANCHO_CODIGO-1:0]  boton_pres;
  logic [cola_solicitudes_pkg::ANCHO_CODIGO-1:0]  memoria;
  logic [cola_solicitudes_pkg::NUM_CODIGOS-1:0]   pendientes;
  logic [1:0]                                     direccion;

  modport master (
    output LE, puertas, accion, piso, boton_pres,
    input  memoria, pendientes, direccion
  );

  modport slave (
    input  LE, puertas, accion, piso, boton_pres,
    output memoria, pendientes, direccion
  );

endinterface
`default_nettype wire

// File: rtl/cola_solicitudes_selector_scan.sv
`default_nettype none
// ============================================================================
// Module      : cola_solicitudes_selector_scan
// Description : Combinational SCAN target selection and code emission.
// Revision    : 1.0 - initial release
// ============================================================================
module cola_solicitudes_selector_scan
  import cola_solicitudes_pkg::*;
(
  input  wire logic [NUM_CODIGOS-1:0]  pendientes,
  input  wire logic [1:0]              piso,
  input  wire dir_t                    direccion,
  output logic                         objetivo_valido,
  output logic [1:0]                   objetivo_piso,
  output logic [ANCHO_CODIGO-1:0]      codigo
);

  logic [3:0]             w_hay;
  logic                   w_arriba_ok;
  logic                   w_abajo_ok;
  logic [1:0]             w_arriba;
  logic [1:0]             w_abajo;
  logic [NUM_CODIGOS-1:0] w_mascara;

  always_comb begin
    for (int f = 0; f < 4; f++) begin
      w_hay[f] = |(pendientes & mascara_piso(2'(f)));
    end
  end

  // Scanning away from the cabin with overwrite leaves the nearest hit.
  always_comb begin
    w_arriba_ok = 1'b0;
    w_arriba    = 2'd0;
    w_abajo_ok  = 1'b0;
    w_abajo     = 2'd0;
    for (int f = 3; f >= 0; f--) begin
      if (w_hay[f] && (2'(f) > piso)) begin
        w_arriba_ok = 1'b1;
        w_arriba    = 2'(f);
      end
    end
    for (int f = 0; f < 4; f++) begin
      if (w_hay[f] && (2'(f) < piso)) begin
        w_abajo_ok = 1'b1;
        w_abajo    = 2'(f);
      end
    end
  end

  always_comb begin
    objetivo_valido = 1'b1;
    objetivo_piso   = piso;
    if (w_hay[piso]) begin
      objetivo_piso = piso;
    end else if (direccion != DIR_DOWN) begin
      if (w_arriba_ok)     objetivo_piso = w_arriba;
      else if (w_abajo_ok) objetivo_piso = w_abajo;
      else                 objetivo_valido = 1'b0;
    end else begin
      if (w_abajo_ok)       objetivo_piso = w_abajo;
      else if (w_arriba_ok) objetivo_piso = w_arriba;
      else                  objetivo_valido = 1'b0;
    end
  end

  // Cabin code first, otherwise the lowest pending hall code on that floor.
  always_comb begin
    w_mascara = pendientes & mascara_piso(objetivo_piso);
    codigo    = COD_NINGUNO;
    if (objetivo_valido) begin
      if (w_mascara[objetivo_piso]) begin
        codigo = {2'b00, objetivo_piso} + 4'd1;
      end else begin
        for (int i = NUM_CODIGOS - 1; i >= 0; i--) begin
          if (w_mascara[i]) codigo = 4'(i + 1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cola_solicitudes.sv
`default_nettype none
// ============================================================================
// Module      : cola_solicitudes
// Description : Pending request memory with SCAN next-instruction output.
// Revision    : 1.0 - initial release
// ============================================================================
module cola_solicitudes
  import cola_solicitudes_pkg::*;
(
  input  wire logic           clk,
  input  wire logic           rst,
  cola_solicitudes_if.slave   bus
);

  logic [ANCHO_CODIGO-1:0] r_prev_btn;
  logic                    r_prev_puertas;
  logic [NUM_CODIGOS-1:0]  r_pendientes;
  logic [ANCHO_CODIGO-1:0] r_memoria;
  dir_t                    r_direccion;

  logic                    w_btn_valido;
  logic                    w_mismo_piso;
  logic [NUM_CODIGOS-1:0]  w_set;
  logic [NUM_CODIGOS-1:0]  w_clear;
  logic [NUM_CODIGOS-1:0]  w_pend_sig;
  logic                    w_obj_valido;
  logic [1:0]              w_obj_piso;
  logic [ANCHO_CODIGO-1:0] w_codigo;
  logic                    w_unused;

  assign w_unused = ^bus.accion;

  assign w_btn_valido = (bus.boton_pres != COD_NINGUNO) &&
                        (bus.boton_pres <= COD_MAX) &&
                        (bus.boton_pres != r_prev_btn);
  // A press for the floor being served is dropped; this also makes the clear win.
  assign w_mismo_piso = bus.puertas && (codigo_a_piso(bus.boton_pres) == bus.piso);
  assign w_set        = (w_btn_valido && !w_mismo_piso) ?
                        (NUM_CODIGOS'(1) << (bus.boton_pres - 4'd1)) : '0;
  assign w_clear      = (bus.puertas && !r_prev_puertas) ? mascara_piso(bus.piso) : '0;
  assign w_pend_sig   = (r_pendientes | w_set) & ~w_clear;

  cola_solicitudes_selector_scan u_selector (
    .pendientes      (r_pendientes),
    .piso            (bus.piso),
    .direccion       (r_direccion),
    .objetivo_valido (w_obj_valido),
    .objetivo_piso   (w_obj_piso),
    .codigo          (w_codigo)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev_btn     <= COD_NINGUNO;
      r_prev_puertas <= 1'b0;
      r_pendientes   <= '0;
      r_memoria      <= COD_NINGUNO;
      r_direccion    <= DIR_IDLE;
    end else begin
      r_prev_btn     <= bus.boton_pres;
      r_prev_puertas <= bus.puertas;
      r_pendientes   <= w_pend_sig;
      if (bus.LE) begin
        r_memoria <= w_codigo;
        if (!w_obj_valido)            r_direccion <= DIR_IDLE;
        else if (w_obj_piso > bus.piso) r_direccion <= DIR_UP;
        else if (w_obj_piso < bus.piso) r_direccion <= DIR_DOWN;
      end
    end
  end

  assign bus.memoria    = r_memoria;
  assign bus.pendientes = r_pendientes;
  assign bus.direccion  = r_direccion;

endmodule
`default_nettype wire

// File: tb/tb_cola_solicitudes.sv
`default_nettype none
// ============================================================================
// Module      : tb_cola_solicitudes
// Description : Directed self-checking bench for cola_solicitudes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cola_solicitudes;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  cola_solicitudes_if bus ();

  cola_solicitudes dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] code);
    bus.boton_pres = code;
    tick();
    bus.boton_pres = 4'd0;
    tick();
  endtask

  task automatic door_rise(input logic [1:0] floor);
    bus.piso    = floor;
    bus.puertas = 1'b1;
    tick();
    bus.puertas = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.LE = 1'b0; bus.puertas = 1'b0; bus.accion = 2'd0;
    bus.piso = 2'd0; bus.boton_pres = 4'd0;
    #1;
    tests++;
    if (bus.pendientes !== 10'h000 || bus.memoria !== 4'd0 || bus.direccion !== 2'd0) begin
      $display("FAIL reset_init: pend=%h mem=%0d dir=%0d expected 000/0/0",
               bus.pendientes, bus.memoria, bus.direccion);
      fails++;
    end
    tick(); tick();
    rst = 1'b1;
    tick();
    for (int c = 1; c <= 10; c++) begin
      bus.boton_pres = 4'(c);
      tick();
    end
    bus.boton_pres = 4'd0;
    tick();
    tests++;
    if (bus.pendientes !== 10'h3FF) begin
      $display("FAIL fill_all: pend=%h expected 3ff", bus.pendientes);
      fails++;
    end
    #2 rst = 1'b0;
    #1;
    tests++;
    if (bus.pendientes !== 10'h000 || bus.memoria !== 4'd0 || bus.direccion !== 2'd0) begin
      $display("FAIL async_reset: pend=%h mem=%0d dir=%0d expected 000/0/0",
               bus.pendientes, bus.memoria, bus.direccion);
      fails++;
    end
    tick();
    rst = 1'b1;
    bus.LE = 1'b1;
    tick();
    bus.LE = 1'b0;
    tests++;
    if (bus.memoria !== 4'd0 || bus.direccion !== 2'd0) begin
      $display("FAIL reset_idle_le: mem=%0d dir=%0d expected 0/0", bus.memoria, bus.direccion);
      fails++;
    end
  endtask

  task automatic test_held_button();
    bus.piso = 2'd0;
    bus.boton_pres = 4'd3;
    repeat (5) tick();
    bus.boton_pres = 4'd0;
    tests++;
    if (bus.pendientes !== 10'h004) begin
      $display("FAIL held_button: pend=%h expected 004", bus.pendientes);
      fails++;
    end
    bus.LE = 1'b1;
    tick();
    bus.LE = 1'b0;
    tests++;
    if (bus.memoria !== 4'd3 || bus.direccion !== 2'd1) begin
      $display("FAIL held_select: mem=%0d dir=%0d expected 3/1", bus.memoria, bus.direccion);
      fails++;
    end
    door_rise(2'd2);
    tests++;
    if (bus.pendientes !== 10'h000) begin
      $display("FAIL clear_floor2: pend=%h expected 000", bus.pendientes);
      fails++;
    end
  endtask

  task automatic test_scan_priority();
    bus.piso = 2'd1;
    press(4'd1);
    press(4'd4);
    bus.LE = 1'b1;
    tick();
    bus.LE = 1'b0;
    tests++;
    if (bus.memoria !== 4'd4 || bus.direccion !== 2'd1) begin
      $display("FAIL scan_up: mem=%0d dir=%0d expected 4/1", bus.memoria, bus.direccion);
      fails++;
    end
    door_rise(2'd3);
    tests++;
    if (bus.pendientes !== 10'h001) begin
      $display("FAIL clear_floor3: pend=%h expected 001", bus.pendientes);
      fails++;
    end
    bus.LE = 1'b1;
    tick();
    bus.LE = 1'b0;
    tests++;
    if (bus.memoria !== 4'd1 || bus.direccion !== 2'd2) begin
      $display("FAIL scan_reverse: mem=%0d dir=%0d expected 1/2", bus.memoria, bus.direccion);
      fails++;
    end
    door_rise(2'd0);
  endtask

  task automatic test_service_clear();
    bus.piso = 2'd0;
    press(4'd2);
    press(4'd6);
    press(4'd7);
    tests++;
    if (bus.pendientes !== 10'h062) begin
      $display("FAIL floor1_pending: pend=%h expected 062", bus.pendientes);
      fails++;
    end
    bus.piso = 2'd1;
    bus.puertas = 1'b1;
    tick();
    tests++;
    if (bus.pendientes !== 10'h000) begin
      $display("FAIL service_clear: pend=%h expected 000", bus.pendientes);
      fails++;
    end
    bus.boton_pres = 4'd6;
    tick();
    bus.boton_pres = 4'd0;
    tests++;
    if (bus.pendientes !== 10'h000) begin
      $display("FAIL open_door_press: pend=%h expected 000", bus.pendientes);
      fails++;
    end
    bus.puertas = 1'b0;
    tick();
  endtask

  task automatic test_le_freeze();
    bus.piso = 2'd1;
    press(4'd10);
    tests++;
    if (bus.pendientes !== 10'h200 || bus.memoria !== 4'd1 || bus.direccion !== 2'd2) begin
      $display("FAIL le_freeze: pend=%h mem=%0d dir=%0d expected 200/1/2",
               bus.pendientes, bus.memoria, bus.direccion);
      fails++;
    end
    bus.LE = 1'b1;
    tick();
    bus.LE = 1'b0;
    tests++;
    if (bus.memoria !== 4'd10 || bus.direccion !== 2'd1) begin
      $display("FAIL le_release: mem=%0d dir=%0d expected 10/1", bus.memoria, bus.direccion);
      fails++;
    end
    door_rise(2'd3);
  endtask

  task automatic test_invalid_conflict();
    bus.piso = 2'd0;
    press(4'd13);
    tests++;
    if (bus.pendientes !== 10'h000) begin
      $display("FAIL invalid_code: pend=%h expected 000", bus.pendientes);
      fails++;
    end
    press(4'd1);
    bus.boton_pres = 4'd2;
    bus.puertas    = 1'b1;
    tick();
    bus.boton_pres = 4'd0;
    bus.puertas    = 1'b0;
    tests++;
    if (bus.pendientes !== 10'h002) begin
      $display("FAIL diff_floor_conflict: pend=%h expected 002", bus.pendientes);
      fails++;
    end
    tick();
    bus.boton_pres = 4'd5;
    bus.puertas    = 1'b1;
    tick();
    bus.boton_pres = 4'd0;
    bus.puertas    = 1'b0;
    tests++;
    if (bus.pendientes !== 10'h002) begin
      $display("FAIL same_floor_conflict: pend=%h expected 002", bus.pendientes);
      fails++;
    end
    tick();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_held_button();
    test_scan_priority();
    test_service_clear();
    test_le_freeze();
    test_invalid_conflict();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
